// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between a CPU port (A) and a secondary master (B).
// One access in flight; all SRAM controls are decoded from registered state.
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              A_req,
    input  logic              A_we,
    input  logic [1:0]        A_be,
    input  logic [ADDR_W-1:0] A_addr,
    input  logic [DATA_W-1:0] A_wdata,
    output logic              A_ack,
    input  logic              B_req,
    input  logic              B_we,
    input  logic [1:0]        B_be,
    input  logic [ADDR_W-1:0] B_addr,
    input  logic [DATA_W-1:0] B_wdata,
    output logic              B_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              sram_drive
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_b;
    logic       gnt_b;
    logic       op_we;
    logic [1:0] op_be;
    logic       any_req;
    logic       pick_b;
    logic       last_access;
    logic       in_access;
    logic       in_done;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            last_b       <= 1'b1;
            gnt_b        <= 1'b0;
            op_we        <= 1'b0;
            op_be        <= '0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            rdata        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_b        <= pick_b;
                        last_b       <= pick_b;
                        op_we        <= pick_b ? B_we    : A_we;
                        op_be        <= pick_b ? B_be    : A_be;
                        ADDR         <= pick_b ? B_addr  : A_addr;
                        Data_to_SRAM <= pick_b ? B_wdata : A_wdata;
                        cnt          <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (last_access && !op_we)
                        rdata <= Data_from_SRAM;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        any_req     = A_req || B_req;
        // B wins only when alone, or on a tie when A was the previous grant
        pick_b      = B_req && (!A_req || !last_b);
        last_access = (cnt == 4'(ACCESS_CYCLES - 1));
        in_access   = (state == ACCESS);
        in_done     = (state == DONE);

        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (last_access) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        CE         = !in_access;
        UB         = !(in_access && op_be[1]);
        LB         = !(in_access && op_be[0]);
        OE         = !(in_access && !op_we);
        WE         = !(in_access && op_we);
        // bus stays driven through DONE after a write for data hold time
        sram_drive = op_we && (in_access || in_done);
        A_ack      = in_done && !gnt_b;
        B_ack      = in_done && gnt_b;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter at ACCESS_CYCLES = 2, 1 and 15, checked cycle by cycle
// against a transaction-level schedule model and a byte-lane SRAM model.
module tb_sram_arbiter;

    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int NCYC = 3000;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [2:0] done         = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [AW-1:0] a);
        if (a == 20'h00123)
            return 16'hBEEF;
        return 16'(a[15:0] * 16'd3 + 16'h1357);
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 20'h00123;
            1:       return 20'h0FFFE;
            2:       return 20'h00010;
            3:       return 20'h00011;
            4:       return 20'h00012;
            5:       return 20'hFFFFF;
            6:       return 20'h00000;
            default: return 20'(32'h00100 + $urandom_range(0, 3));
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int N = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;

        logic          Reset;
        logic          A_req, B_req, A_we, B_we, A_ack, B_ack;
        logic [1:0]    A_be, B_be;
        logic [AW-1:0] A_addr, B_addr, ADDR;
        logic [DW-1:0] A_wdata, B_wdata, rdata, Data_to_SRAM, Data_from_SRAM;
        logic          CE, UB, LB, OE, WE, sram_drive;

        logic [1:0]    rq, wq;
        logic [1:0]    bq [2];
        logic [AW-1:0] aq [2];
        logic [DW-1:0] dq [2];

        logic [15:0] pin_mem [int unsigned];
        logic [15:0] ref_mem [int unsigned];

        assign A_req   = rq[0];
        assign B_req   = rq[1];
        assign A_we    = wq[0];
        assign B_we    = wq[1];
        assign A_be    = bq[0];
        assign B_be    = bq[1];
        assign A_addr  = aq[0];
        assign B_addr  = aq[1];
        assign A_wdata = dq[0];
        assign B_wdata = dq[1];

        sram_arbiter #(
            .ADDR_W(AW),
            .DATA_W(DW),
            .ACCESS_CYCLES(N)
        ) u_dut (
            .Clk(Clk),
            .Reset(Reset),
            .A_req(A_req),
            .A_we(A_we),
            .A_be(A_be),
            .A_addr(A_addr),
            .A_wdata(A_wdata),
            .A_ack(A_ack),
            .B_req(B_req),
            .B_we(B_we),
            .B_be(B_be),
            .B_addr(B_addr),
            .B_wdata(B_wdata),
            .B_ack(B_ack),
            .rdata(rdata),
            .ADDR(ADDR),
            .CE(CE),
            .UB(UB),
            .LB(LB),
            .OE(OE),
            .WE(WE),
            .Data_to_SRAM(Data_to_SRAM),
            .Data_from_SRAM(Data_from_SRAM),
            .sram_drive(sram_drive)
        );

        initial begin
            int            txn_start, free_at, txn_port, k, p;
            logic          last_b, t_we, acc, dn, force_req;
            logic [1:0]    t_be;
            logic [AW-1:0] exp_addr;
            logic [DW-1:0] exp_dout, exp_rdata, t_rdata, w;
            logic [7:0]    exp_ctl;

            rq = '0;
            wq = '0;
            for (int i = 0; i < 2; i++) begin
                bq[i] = '0;
                aq[i] = '0;
                dq[i] = '0;
            end
            Reset          = 1'b1;
            Data_from_SRAM = 16'h0BAD;
            last_b         = 1'b1;
            txn_start      = -1;
            txn_port       = 0;
            free_at        = 0;
            t_we           = 1'b0;
            t_be           = '0;
            t_rdata        = '0;
            exp_addr       = '0;
            exp_dout       = '0;
            exp_rdata      = '0;

            for (int c = 0; c < NCYC; c++) begin
                @(negedge Clk);

                // expected pins for cycle c from the active transaction's phase
                k   = (txn_start >= 0) ? c - txn_start : -1;
                acc = (k >= 1) && (k <= N);
                dn  = (k == N + 1);
                if (dn && !t_we)
                    exp_rdata = t_rdata;
                exp_ctl = {!acc, !(acc && t_be[1]), !(acc && t_be[0]), !(acc && !t_we),
                           !(acc && t_we), (acc || dn) && t_we,
                           dn && (txn_port == 0), dn && (txn_port == 1)};
                check_eq($sformatf("n%0d_ctl", N), {CE, UB, LB, OE, WE, sram_drive, A_ack, B_ack}, exp_ctl);
                check_eq($sformatf("n%0d_addr", N), ADDR, exp_addr);
                check_eq($sformatf("n%0d_dout", N), Data_to_SRAM, exp_dout);
                check_eq($sformatf("n%0d_rdata", N), rdata, exp_rdata);

                // SRAM behaviour seen through the pins
                if (!CE && !WE && sram_drive) begin
                    w = pin_mem.exists(ADDR) ? pin_mem[ADDR] : init_word(ADDR);
                    if (!UB) w[15:8] = Data_to_SRAM[15:8];
                    if (!LB) w[7:0]  = Data_to_SRAM[7:0];
                    pin_mem[ADDR] = w;
                end
                if (!CE && !OE)
                    Data_from_SRAM = pin_mem.exists(ADDR) ? pin_mem[ADDR] : init_word(ADDR);
                else
                    Data_from_SRAM = 16'h0BAD;

                // requester behaviour for cycle c
                force_req = (c < 40);
                for (int q = 0; q < 2; q++) begin
                    if (dn && txn_port == q) begin
                        rq[q] = force_req || ($urandom_range(0, 1) == 0);
                    end else if (!rq[q]) begin
                        rq[q] = force_req || ($urandom_range(0, 2) == 0);
                    end else if (acc && txn_port == q && !force_req && $urandom_range(0, 3) == 0) begin
                        rq[q] = 1'b0;
                        continue;
                    end else begin
                        continue;
                    end
                    if (rq[q]) begin
                        wq[q] = 1'($urandom_range(0, 1));
                        bq[q] = 2'($urandom_range(0, 3));
                        aq[q] = pick_addr();
                        dq[q] = 16'($urandom);
                    end
                end
                Reset = (c < 2) || ($urandom_range(0, 149) == 0);

                // schedule model: what the next edge commits
                if (Reset) begin
                    txn_start = -1;
                    free_at   = c + 1;
                    last_b    = 1'b1;
                    exp_addr  = '0;
                    exp_dout  = '0;
                    exp_rdata = '0;
                end else if (c >= free_at && (rq[0] || rq[1])) begin
                    p         = (rq[0] && rq[1]) ? (last_b ? 0 : 1) : (rq[0] ? 0 : 1);
                    last_b    = (p == 1);
                    txn_start = c;
                    free_at   = c + N + 2;
                    txn_port  = p;
                    t_we      = wq[p];
                    t_be      = bq[p];
                    exp_addr  = aq[p];
                    exp_dout  = dq[p];
                    w = ref_mem.exists(aq[p]) ? ref_mem[aq[p]] : init_word(aq[p]);
                    if (t_we) begin
                        if (t_be[1]) w[15:8] = dq[p][15:8];
                        if (t_be[0]) w[7:0]  = dq[p][7:0];
                        ref_mem[aq[p]] = w;
                    end else begin
                        t_rdata = w;
                    end
                end
            end
            done[gi] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < NCYC + 20 && done != 3'b111; i++)
            @(posedge Clk);
        check_eq("all_instances_done", 32'(done), 32'h7);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
